// File: rtl/wb_stage_if.sv
// EXU -> writeback handshake: one retiring instruction per in_valid & in_ready.
interface wb_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_result;

  modport master (
    output in_valid, in_rd, in_rd_wen, in_is_load, in_funct3, in_addr_lo, in_result,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd, in_rd_wen, in_is_load, in_funct3, in_addr_lo, in_result,
    output in_ready
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: holds one retiring instruction, waits for load data, formats
// it and drives the register-file write port; also tracks pending rd and instret.
module wb_stage #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  wb_stage_if.slave        exu,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic             rf_wen,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             pend_valid,
  output logic [4:0]       pend_rd,
  output logic             retire,
  output logic             load_err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_MEM = 2'd1;
  localparam logic [1:0] WRITE    = 2'd2;

  logic [1:0]  state, state_nxt;
  logic [4:0]  rd_q;
  logic        wen_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_q;
  logic [31:0] data_q;
  logic        err_q;

  logic        accept;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic        load_bad;

  assign exu.in_ready = (state == IDLE) || (state == WRITE);
  assign accept       = exu.in_valid && exu.in_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps synthesis from inferring a latch.
  always_comb begin
    load_byte = mem_rdata[{addr_q, 3'b000} +: 8];
    load_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    load_bad  = 1'b0;
    case (funct3_q)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b010:  load_data = mem_rdata;
      3'b100:  load_data = {24'd0, load_byte};
      3'b101:  load_data = {16'd0, load_half};
      default: load_bad  = 1'b1;  // raw word is written, error flagged at retire
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, WRITE: begin
        if (accept) state_nxt = exu.in_is_load ? WAIT_MEM : WRITE;
        else        state_nxt = IDLE;
      end
      WAIT_MEM: if (mem_rvalid) state_nxt = WRITE;
      default:  state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_q     <= 5'd0;
      wen_q    <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 2'd0;
      data_q   <= 32'd0;
      err_q    <= 1'b0;
      instret  <= '0;
    end else begin
      state <= state_nxt;
      if (state == WRITE) instret <= instret + CNT_W'(1);
      if (accept) begin
        rd_q     <= exu.in_rd;
        wen_q    <= exu.in_rd_wen;
        funct3_q <= exu.in_funct3;
        addr_q   <= exu.in_addr_lo;
        if (!exu.in_is_load) begin
          data_q <= exu.in_result;
          err_q  <= 1'b0;
        end
      end else if (state == WAIT_MEM && mem_rvalid) begin
        data_q <= load_data;
        err_q  <= load_bad;
      end
    end
  end

  assign retire     = (state == WRITE);
  assign rf_wen     = retire && wen_q && (rd_q != 5'd0);
  assign rf_waddr   = rd_q;
  assign rf_wdata   = data_q;
  assign load_err   = retire && err_q;
  assign pend_valid = (state != IDLE);
  assign pend_rd    = (pend_valid && wen_q) ? rd_q : 5'd0;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: an outstanding-instruction model checked every cycle,
// plus directed scenarios with literal expectations; a CNT_W=4 copy covers wrap.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = 32'd0;

  wb_stage_if exu64 ();
  wb_stage_if exu4 ();

  logic        rf_wen, pend_valid, retire, load_err;
  logic [4:0]  rf_waddr, pend_rd;
  logic [31:0] rf_wdata;
  logic [63:0] instret;

  logic        rf_wen4, pend_valid4, retire4, load_err4;
  logic [4:0]  rf_waddr4, pend_rd4;
  logic [31:0] rf_wdata4;
  logic [3:0]  instret4;

  assign exu4.in_valid   = exu64.in_valid;
  assign exu4.in_rd      = exu64.in_rd;
  assign exu4.in_rd_wen  = exu64.in_rd_wen;
  assign exu4.in_is_load = exu64.in_is_load;
  assign exu4.in_funct3  = exu64.in_funct3;
  assign exu4.in_addr_lo = exu64.in_addr_lo;
  assign exu4.in_result  = exu64.in_result;

  wb_stage #(.CNT_W(64)) dut (
    .clk(clk), .rst(rst), .exu(exu64),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_valid(pend_valid), .pend_rd(pend_rd),
    .retire(retire), .load_err(load_err), .instret(instret)
  );

  wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .exu(exu4),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
    .pend_valid(pend_valid4), .pend_rd(pend_rd4),
    .retire(retire4), .load_err(load_err4), .instret(instret4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Load formatting from the ISA rules, with plain shifts and masks.
  function automatic logic [31:0] model_fmt(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * int'(a))) & 32'h0000_00FF;
    h = (w >> ((a >= 2'd2) ? 16 : 0)) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Model: at most one instruction outstanding; either waiting for memory or
  // being written back this cycle.
  logic        m_busy_mem;
  logic [4:0]  m_mem_rd;
  logic        m_mem_wen;
  logic [2:0]  m_mem_f3;
  logic [1:0]  m_mem_a;
  logic        m_wr;
  logic [4:0]  m_wr_rd;
  logic        m_wr_wen;
  logic [31:0] m_wr_data;
  logic        m_wr_err;
  logic [63:0] m_count;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy_mem = 1'b0;
      m_wr       = 1'b0;
      m_count    = 64'd0;
      m_mem_rd = 5'd0; m_mem_wen = 1'b0; m_mem_f3 = 3'd0; m_mem_a = 2'd0;
      m_wr_rd = 5'd0; m_wr_wen = 1'b0; m_wr_data = 32'd0; m_wr_err = 1'b0;
    end else begin
      if (m_wr) m_count = m_count + 64'd1;
      m_wr = 1'b0;
      if (m_busy_mem) begin
        if (mem_rvalid) begin
          m_busy_mem = 1'b0;
          m_wr       = 1'b1;
          m_wr_rd    = m_mem_rd;
          m_wr_wen   = m_mem_wen;
          m_wr_data  = model_fmt(m_mem_f3, m_mem_a, mem_rdata);
          m_wr_err   = (m_mem_f3 == 3'd3) || (m_mem_f3 == 3'd6) || (m_mem_f3 == 3'd7);
        end
      end else if (exu64.in_valid) begin
        if (exu64.in_is_load) begin
          m_busy_mem = 1'b1;
          m_mem_rd   = exu64.in_rd;
          m_mem_wen  = exu64.in_rd_wen;
          m_mem_f3   = exu64.in_funct3;
          m_mem_a    = exu64.in_addr_lo;
        end else begin
          m_wr      = 1'b1;
          m_wr_rd   = exu64.in_rd;
          m_wr_wen  = exu64.in_rd_wen;
          m_wr_data = exu64.in_result;
          m_wr_err  = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", exu64.in_ready, !m_busy_mem);
    check("retire", retire, m_wr);
    check("rf_wen", rf_wen, m_wr && m_wr_wen && (m_wr_rd != 5'd0));
    check("load_err", load_err, m_wr && m_wr_err);
    if (m_wr) begin
      check("rf_waddr", rf_waddr, m_wr_rd);
      check("rf_wdata", rf_wdata, m_wr_data);
    end
    check("pend_valid", pend_valid, m_busy_mem || m_wr);
    check("pend_rd", pend_rd, m_busy_mem ? (m_mem_wen ? m_mem_rd : 5'd0)
                            : (m_wr && m_wr_wen) ? m_wr_rd : 5'd0);
    check("instret", instret, m_count);
    check("instret4", instret4, {60'd0, m_count[3:0]});
  end

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t wlog[$];
  int  cyc = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (!rst && rf_wen) wlog.push_back('{cyc, rf_waddr, rf_wdata});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Present an instruction and return just after the edge that accepts it.
  task automatic send(input logic [4:0] rd, input logic wen, input logic ld,
                      input logic [2:0] f3, input logic [1:0] a, input logic [31:0] res);
    bit done;
    exu64.in_valid   = 1'b1;
    exu64.in_rd      = rd;
    exu64.in_rd_wen  = wen;
    exu64.in_is_load = ld;
    exu64.in_funct3  = f3;
    exu64.in_addr_lo = a;
    exu64.in_result  = res;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = exu64.in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    exu64.in_valid = 1'b0;
  endtask

  task automatic pulse_rvalid(input logic [31:0] w);
    mem_rdata  = w;
    mem_rvalid = 1'b1;
    @(posedge clk);
    #1;
    mem_rvalid = 1'b0;
  endtask

  task automatic do_load(input string name, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] a, input logic [31:0] w,
                         input logic [31:0] exp, input logic exp_err);
    send(rd, 1'b1, 1'b1, f3, a, 32'd0);
    idle();
    @(posedge clk);
    #1;
    pulse_rvalid(w);
    @(negedge clk);
    check({name, "_retire"}, retire, 1'b1);
    check({name, "_wdata"}, rf_wdata, exp);
    check({name, "_waddr"}, rf_waddr, rd);
    check({name, "_err"}, load_err, exp_err);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exu64.in_valid = 1'b0; exu64.in_rd = 5'd0; exu64.in_rd_wen = 1'b0;
    exu64.in_is_load = 1'b0; exu64.in_funct3 = 3'd0; exu64.in_addr_lo = 2'd0;
    exu64.in_result = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", exu64.in_ready, 1'b1);
    check("rst_rf_wen", rf_wen, 1'b0);
    check("rst_rf_waddr", rf_waddr, 5'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_pend", pend_valid, 1'b0);
    check("rst_instret", instret, 64'd0);

    check("model_lb", model_fmt(3'd0, 2'd3, 32'h80F17F01), 32'hFFFF_FF80);
    check("model_lbu", model_fmt(3'd4, 2'd1, 32'h80F17F01), 32'h0000_007F);
    check("model_lh", model_fmt(3'd1, 2'd3, 32'h80F17F01), 32'hFFFF_80F1);
    check("model_lhu", model_fmt(3'd5, 2'd1, 32'h80F17F01), 32'h0000_7F01);

    @(posedge clk);
    #1;
    wlog.delete();
    send(5'd1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h11);
    send(5'd2, 1'b1, 1'b0, 3'd0, 2'd0, 32'h22);
    send(5'd3, 1'b1, 1'b0, 3'd0, 2'd0, 32'h33);
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("b2b_count", wlog.size(), 3);
    if (wlog.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("b2b_addr", wlog[i].addr, i + 1);
        check("b2b_data", wlog[i].data, 32'h11 * (i + 1));
      end
      check("b2b_consec", wlog[2].cyc - wlog[0].cyc, 2);
    end
    check("b2b_instret", instret, 64'd3);
    @(posedge clk);
    #1;

    do_load("lb", 5'd4, 3'd0, 2'd3, 32'h80F17F01, 32'hFFFF_FF80, 1'b0);
    do_load("lbu", 5'd4, 3'd4, 2'd1, 32'h80F17F01, 32'h0000_007F, 1'b0);
    do_load("lh", 5'd4, 3'd1, 2'd2, 32'h80F17F01, 32'hFFFF_80F1, 1'b0);
    do_load("lhu", 5'd4, 3'd5, 2'd0, 32'h80F17F01, 32'h0000_7F01, 1'b0);

    send(5'd5, 1'b1, 1'b1, 3'd2, 2'd3, 32'd0);
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_ready", exu64.in_ready, 1'b0);
      check("stall_pend", pend_valid, 1'b1);
      check("stall_rd", pend_rd, 5'd5);
      @(posedge clk);
      #1;
    end
    pulse_rvalid(32'hDEADBEEF);
    @(negedge clk);
    check("stall_wen", rf_wen, 1'b1);
    check("stall_waddr", rf_waddr, 5'd5);
    check("stall_wdata", rf_wdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;

    send(5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 32'h55);
    idle();
    @(negedge clk);
    check("x0_retire", retire, 1'b1);
    check("x0_wen", rf_wen, 1'b0);
    @(posedge clk);
    #1;
    do_load("ld011", 5'd7, 3'd3, 2'd1, 32'h12345678, 32'h12345678, 1'b1);

    send(5'd9, 1'b1, 1'b1, 3'd2, 2'd0, 32'd0);
    idle();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wlog.delete();
    pulse_rvalid(32'hCAFEF00D);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rstld_nowrite", wlog.size(), 0);
    check("rstld_ready", exu64.in_ready, 1'b1);
    check("rstld_pend", pend_valid, 1'b0);
    check("rstld_instret", instret, 64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) send(5'(i + 1), 1'b1, 1'b0, 3'd0, 2'd0, 32'(i));
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("wrap_instret4", instret4, 4'd0);
    check("wrap_instret64", instret, 64'd16);

    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
